// File: rtl/pep_ks_cmd_dispatch_if.sv
// pep_ks_cmd_dispatch_if: sequencer command, enquiry and fork handshake bundle of the KS dispatcher
interface pep_ks_cmd_dispatch_if #(
  parameter int CMD_W   = 64,
  parameter int PID_W   = 5,
  parameter int CT_NB_W = 6,
  parameter int COL_NB  = 4,
  parameter int CONS_NB = 2
);
  localparam int LW = $clog2(COL_NB);
  logic [CMD_W-1:0]              seq_ks_cmd;
  logic [PID_W-1:0]              seq_ks_cmd_first_pid;
  logic [CT_NB_W-1:0]            seq_ks_cmd_ct_nb_m1;
  logic [LW-1:0]                 seq_ks_cmd_ks_loop;
  logic                          seq_ks_cmd_avail;
  logic                          ks_seq_cmd_enquiry;
  logic [CONS_NB*CMD_W-1:0]      cons_cmd;
  logic [CONS_NB-1:0]            cons_cmd_vld;
  logic [CONS_NB-1:0]            cons_cmd_rdy;
  logic [CT_NB_W+PID_W+LW-1:0]   proc_cmd;
  logic                          proc_cmd_vld;
  logic                          proc_cmd_rdy;
  modport master (
    input  seq_ks_cmd, seq_ks_cmd_first_pid, seq_ks_cmd_ct_nb_m1, seq_ks_cmd_ks_loop, seq_ks_cmd_avail,
    input  cons_cmd_rdy, proc_cmd_rdy,
    output ks_seq_cmd_enquiry, cons_cmd, cons_cmd_vld, proc_cmd, proc_cmd_vld
  );
  modport slave (
    output seq_ks_cmd, seq_ks_cmd_first_pid, seq_ks_cmd_ct_nb_m1, seq_ks_cmd_ks_loop, seq_ks_cmd_avail,
    output cons_cmd_rdy, proc_cmd_rdy,
    input  ks_seq_cmd_enquiry, cons_cmd, cons_cmd_vld, proc_cmd, proc_cmd_vld
  );
endinterface

// File: rtl/pep_ks_cmd_dispatch.sv
// pep_ks_cmd_dispatch: KS command FIFO + fork, KSK slot tracking, loop counter, credit-limited enquiries (option: PEP_KS_DISPATCH_LOOP_CHECK_EN)
module pep_ks_cmd_dispatch #(
  parameter int CMD_W          = 64,
  parameter int PID_W          = 5,
  parameter int CT_NB_W        = 6,
  parameter int COL_NB         = 4,
  parameter int KSK_SLOT_NB    = 3,
  parameter int CMD_FIFO_DEPTH = 2,
  parameter int CONS_NB        = 2,
  parameter int ENQ_INIT_DLY   = 8
) (
  input  logic                               clk,
  input  logic                               s_rst_n,
  input  logic                               reset_cache,
  pep_ks_cmd_dispatch_if.master              bus,
  input  logic                               proc_almost_done,
  input  logic                               inc_ksk_wr_ptr,
  input  logic                               inc_ksk_rd_ptr,
  output logic [$clog2(KSK_SLOT_NB+1)-1:0]   ksk_cnt,
  output logic                               ksk_avail,
  output logic                               ksk_full,
  output logic [2:0]                         error
);
  localparam int LW = $clog2(COL_NB);
  localparam int PW = CMD_FIFO_DEPTH > 1 ? $clog2(CMD_FIFO_DEPTH) : 1;
  localparam int FW = $clog2(CMD_FIFO_DEPTH+1);
  localparam int KW = $clog2(KSK_SLOT_NB+1);
  localparam int TW = $clog2(ENQ_INIT_DLY+1);
  localparam int EW = CMD_W+CT_NB_W+PID_W;
  if (COL_NB < 2 || KSK_SLOT_NB < 1 || CMD_FIFO_DEPTH < 1 || CONS_NB < 1 || ENQ_INIT_DLY < 1) begin : g_bad_cfg
    $fatal(1, "pep_ks_cmd_dispatch: illegal parameter set");
  end
  logic              reset_loop;
  logic [EW-1:0]     mem [CMD_FIFO_DEPTH];
  logic [EW-1:0]     head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     occ, req, req_nxt, outst;
  logic              head_vld, full, push, pop;
  logic [CONS_NB:0]  done, hs;
  logic [LW-1:0]     ks_loop;
  logic              wr_q, ksk_wr_bad, ksk_rd_bad, loop_err;
  logic [TW-1:0]     tmr;
  logic              tmr_exp, tmr_hit, enq_iss;
  int                req_sum;
  assign head     = mem[rd_ptr];
  assign head_vld = occ != '0;
  assign full     = occ == FW'(CMD_FIFO_DEPTH);
  assign hs       = {bus.proc_cmd_vld & bus.proc_cmd_rdy, bus.cons_cmd_vld & bus.cons_cmd_rdy};
  assign pop      = head_vld & (&(done | hs));
  assign push     = bus.seq_ks_cmd_avail & (~full | pop);
  assign bus.proc_cmd_vld = head_vld & ~done[CONS_NB];
  assign bus.cons_cmd_vld = {CONS_NB{head_vld}} & ~done[CONS_NB-1:0];
  assign bus.cons_cmd     = {CONS_NB{head[EW-1 -: CMD_W]}};
  assign bus.proc_cmd     = {head[CT_NB_W+PID_W-1:0], ks_loop};
  assign ksk_avail  = ksk_cnt != '0;
  assign ksk_full   = ksk_cnt == KW'(KSK_SLOT_NB);
  assign ksk_wr_bad = wr_q & ~inc_ksk_rd_ptr & ksk_full;
  assign ksk_rd_bad = inc_ksk_rd_ptr & ~wr_q & ~ksk_avail;
  assign tmr_exp = tmr == TW'(ENQ_INIT_DLY);
  assign tmr_hit = (tmr == TW'(ENQ_INIT_DLY-1)) & ~reset_loop;
  assign enq_iss = (req != '0) & tmr_exp & (int'(outst) + int'(occ) < CMD_FIFO_DEPTH);
  // pending enquiry requests, saturating at the FIFO depth
  always_comb begin
    req_sum = int'(req) + int'(tmr_hit) + int'(proc_almost_done) - int'(enq_iss);
    req_nxt = req_sum > CMD_FIFO_DEPTH ? FW'(CMD_FIFO_DEPTH) : FW'(req_sum);
  end
`ifdef PEP_KS_DISPATCH_LOOP_CHECK_EN
  logic [LW-1:0] exp_loop;
  // expected column index of the next accepted push
  always_ff @(posedge clk) begin
    if (!s_rst_n || reset_loop) exp_loop <= '0;
    else if (push) exp_loop <= exp_loop == LW'(COL_NB-1) ? '0 : exp_loop + 1'b1;
  end
  assign loop_err = push & (bus.seq_ks_cmd_ks_loop != exp_loop);
`else
  logic unused_loop;
  assign unused_loop = ^bus.seq_ks_cmd_ks_loop;
  assign loop_err = 1'b0;
`endif
  // payload storage needs no reset; valid is carried by occ
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.seq_ks_cmd, bus.seq_ks_cmd_ct_nb_m1, bus.seq_ks_cmd_first_pid};
  end
  // FIFO pointers, fork completion flags, column loop counter
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      done    <= '0;
      ks_loop <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(CMD_FIFO_DEPTH-1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(CMD_FIFO_DEPTH-1) ? '0 : rd_ptr + 1'b1;
      occ     <= occ + FW'(push) - FW'(pop);
      done    <= pop ? '0 : done | hs;
      ks_loop <= (reset_loop | (hs[CONS_NB] & (ks_loop == LW'(COL_NB-1)))) ? '0 : ks_loop + LW'(hs[CONS_NB]);
    end
  end
  // KSK occupancy: write strobe lags one cycle, read strobe is immediate
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      wr_q    <= 1'b0;
      ksk_cnt <= '0;
    end else begin
      wr_q    <= inc_ksk_wr_ptr;
      ksk_cnt <= reset_loop ? '0 : ksk_cnt + KW'(wr_q & ~inc_ksk_rd_ptr & ~ksk_full) - KW'(inc_ksk_rd_ptr & ~wr_q & ksk_avail);
    end
  end
  // enquiry timer, request/outstanding credit and registered enquiry pulse
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      reset_loop             <= 1'b0;
      tmr                    <= '0;
      req                    <= '0;
      outst                  <= '0;
      bus.ks_seq_cmd_enquiry <= 1'b0;
    end else begin
      reset_loop             <= reset_cache;
      tmr                    <= reset_loop ? '0 : tmr + TW'(!tmr_exp);
      req                    <= req_nxt;
      outst                  <= reset_loop ? '0 : (enq_iss & ~bus.seq_ks_cmd_avail) ? outst + 1'b1 :
                                (~enq_iss & bus.seq_ks_cmd_avail & (outst != '0)) ? outst - 1'b1 : outst;
      bus.ks_seq_cmd_enquiry <= enq_iss;
    end
  end
  // sticky error flags, cleared only by s_rst_n
  always_ff @(posedge clk) begin
    if (!s_rst_n) error <= '0;
    else error <= error | {loop_err, ksk_wr_bad | ksk_rd_bad, bus.seq_ks_cmd_avail & ~push};
  end
endmodule

// File: tb/tb_pep_ks_cmd_dispatch.sv
// tb_pep_ks_cmd_dispatch: directed/table-driven checks of the KS command dispatcher
module tb_pep_ks_cmd_dispatch;
  localparam int CMD_W = 64, PID_W = 5, CT_NB_W = 6, COL_NB = 4, KSK = 3, DEPTH = 2, CONS_NB = 2, DLY = 8;
  logic clk = 1'b0, s_rst_n = 1'b0, reset_cache = 1'b0, proc_almost_done = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0] ksk_cnt;
  logic ksk_avail, ksk_full;
  logic [2:0] error;
  int checks = 0, errors = 0;
  int n_proc = 0, n_c0 = 0, n_c1 = 0, n_enq = 0;
  int loops[$];
  typedef struct { int wr, rd, cnt, full, avail, err; } kvec_t;
  kvec_t kv[12];
  always #5 clk = ~clk;
  pep_ks_cmd_dispatch_if #(.CMD_W(CMD_W), .PID_W(PID_W), .CT_NB_W(CT_NB_W), .COL_NB(COL_NB), .CONS_NB(CONS_NB)) bus ();
  pep_ks_cmd_dispatch #(.CMD_W(CMD_W), .PID_W(PID_W), .CT_NB_W(CT_NB_W), .COL_NB(COL_NB), .KSK_SLOT_NB(KSK),
    .CMD_FIFO_DEPTH(DEPTH), .CONS_NB(CONS_NB), .ENQ_INIT_DLY(DLY)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .reset_cache(reset_cache), .bus(bus), .proc_almost_done(proc_almost_done),
    .inc_ksk_wr_ptr(wr), .inc_ksk_rd_ptr(rd), .ksk_cnt(ksk_cnt), .ksk_avail(ksk_avail), .ksk_full(ksk_full), .error(error)
  );
  always @(negedge clk) begin
    if (s_rst_n) begin
      n_proc += int'(bus.proc_cmd_vld & bus.proc_cmd_rdy);
      n_c0   += int'(bus.cons_cmd_vld[0] & bus.cons_cmd_rdy[0]);
      n_c1   += int'(bus.cons_cmd_vld[1] & bus.cons_cmd_rdy[1]);
      n_enq  += int'(bus.ks_seq_cmd_enquiry);
      if (bus.proc_cmd_vld & bus.proc_cmd_rdy) loops.push_back(int'(bus.proc_cmd[1:0]));
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    s_rst_n = 1'b0;
    reset_cache = 1'b0;
    proc_almost_done = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    bus.seq_ks_cmd_avail = 1'b0;
    bus.seq_ks_cmd = '0;
    bus.seq_ks_cmd_first_pid = '0;
    bus.seq_ks_cmd_ct_nb_m1 = '0;
    bus.seq_ks_cmd_ks_loop = '0;
    bus.cons_cmd_rdy = '1;
    bus.proc_cmd_rdy = 1'b1;
    step(3);
    s_rst_n = 1'b1;
  endtask
  task automatic push(input logic [63:0] c, input int pid, input int ct, input int lp);
    bus.seq_ks_cmd = c;
    bus.seq_ks_cmd_first_pid = 5'(pid);
    bus.seq_ks_cmd_ct_nb_m1 = 6'(ct);
    bus.seq_ks_cmd_ks_loop = 2'(lp);
    bus.seq_ks_cmd_avail = 1'b1;
    step(1);
    bus.seq_ks_cmd_avail = 1'b0;
  endtask
  initial begin
    int first, cnt, e0, p0, c00, c10;
    int exp_loops[6];
    kv = '{'{1,0,0,0,0,0}, '{1,0,1,0,1,0}, '{1,0,2,0,1,0}, '{0,0,3,1,1,0},
           '{1,0,3,1,1,0}, '{1,0,3,1,1,2}, '{0,1,3,1,1,2}, '{0,1,2,0,1,2},
           '{0,1,1,0,1,2}, '{0,1,0,0,0,2}, '{1,0,0,0,0,2}, '{0,1,0,0,0,2}};
    exp_loops = '{0, 1, 2, 3, 0, 1};
    // reset state and initial enquiry timing
    do_reset;
    chk("rst_proc_vld", bus.proc_cmd_vld, 0);
    chk("rst_cons_vld", bus.cons_cmd_vld, 0);
    chk("rst_enq", bus.ks_seq_cmd_enquiry, 0);
    chk("rst_ksk", {ksk_cnt, ksk_avail, ksk_full}, 0);
    chk("rst_error", error, 0);
    first = 0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (bus.ks_seq_cmd_enquiry) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("enq_first_cycle", first, 9);
    chk("enq_pulse_count", cnt, 1);
    // fork with one slow consumer
    do_reset;
    step(12);
    p0 = n_proc;
    c00 = n_c0;
    c10 = n_c1;
    bus.cons_cmd_rdy = 2'b01;
    push(64'hDEAD_BEEF_0123_4567, 3, 5, 0);
    chk("fork_proc_vld", bus.proc_cmd_vld, 1);
    chk("fork_cons_vld", bus.cons_cmd_vld, 2'b11);
    chk("fork_proc_cmd", bus.proc_cmd, {6'd5, 5'd3, 2'd0});
    chk("fork_cons1_cmd", bus.cons_cmd[127:64], 64'hDEAD_BEEF_0123_4567);
    step(1);
    chk("fork_after_hs_proc", bus.proc_cmd_vld, 0);
    chk("fork_after_hs_cons", bus.cons_cmd_vld, 2'b10);
    step(3);
    chk("fork_cons1_held", bus.cons_cmd_vld, 2'b10);
    bus.cons_cmd_rdy = 2'b11;
    step(1);
    chk("fork_popped_cons", bus.cons_cmd_vld, 0);
    chk("fork_popped_proc", bus.proc_cmd_vld, 0);
    step(3);
    chk("fork_n_proc", n_proc - p0, 1);
    chk("fork_n_cons0", n_c0 - c00, 1);
    chk("fork_n_cons1", n_c1 - c10, 1);
    // ks_loop sequence and reset_loop
    do_reset;
    loops.delete();
    for (int i = 0; i < 6; i++) push(64'(i + 100), i, i, i % 4);
    step(3);
    chk("loop_hs_count", loops.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("loop_seq_%0d", i), (i < loops.size()) ? loops[i] : -1, exp_loops[i]);
    reset_cache = 1'b1;
    step(1);
    reset_cache = 1'b0;
    step(2);
    push(64'h77, 1, 1, 0);
    step(2);
    chk("loop_after_reset_loop", (loops.size() > 6) ? loops[6] : -1, 0);
    // KSK counter table
    do_reset;
    for (int i = 0; i < 12; i++) begin
      wr = 1'(kv[i].wr);
      rd = 1'(kv[i].rd);
      step(1);
      chk($sformatf("ksk_cnt_%0d", i), ksk_cnt, kv[i].cnt);
      chk($sformatf("ksk_full_%0d", i), ksk_full, kv[i].full);
      chk($sformatf("ksk_avail_%0d", i), ksk_avail, kv[i].avail);
      chk($sformatf("ksk_err_%0d", i), error, kv[i].err);
    end
    wr = 1'b0;
    rd = 1'b0;
    do_reset;
    rd = 1'b1;
    step(1);
    rd = 1'b0;
    chk("ksk_rd_empty_err", error, 3'b010);
    chk("ksk_rd_empty_cnt", ksk_cnt, 0);
    // enquiry credit limit and FIFO overflow
    do_reset;
    step(12);
    e0 = n_enq;
    for (int i = 0; i < 5; i++) begin
      proc_almost_done = 1'b1;
      step(1);
      proc_almost_done = 1'b0;
      step(2);
    end
    step(5);
    chk("enq_credit_limit", n_enq - e0, 1);
    bus.proc_cmd_rdy = 1'b0;
    bus.cons_cmd_rdy = 2'b00;
    push(64'h1, 0, 0, 0);
    push(64'h2, 0, 0, 1);
    step(3);
    chk("enq_full_fifo", n_enq - e0, 1);
    chk("ovf_before", error, 0);
    push(64'h3, 0, 0, 2);
    step(1);
    chk("ovf_error", error, 3'b001);
    chk("ovf_head_kept", bus.cons_cmd[63:0], 64'h1);
    // loop index check
    do_reset;
    push(64'h10, 0, 0, 0);
    push(64'h11, 0, 0, 1);
    step(2);
    chk("loopchk_ok", error, 0);
    push(64'h12, 0, 0, 3);
    step(1);
`ifdef PEP_KS_DISPATCH_LOOP_CHECK_EN
    chk("loopchk_mismatch", error, 3'b100);
`else
    chk("loopchk_disabled", error, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
